// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: MIPS funct codes and FSM states.
// Also imported by the control unit for MFHI/MFLO decode.
package mdu_pkg;

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter_core.sv
// Iterative datapath: one shift-add (multiply) or restoring shift-subtract (divide)
// step per cycle on unsigned magnitudes. After N_BITS steps {o_hi,o_lo} = product or {rem,quot}.
module mdu_iter_core #(
  parameter int N_BITS = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_div,
  input  logic [N_BITS-1:0] i_x,
  input  logic [N_BITS-1:0] i_y,
  output logic [N_BITS-1:0] o_hi,
  output logic [N_BITS-1:0] o_lo,
  output logic              o_last
);

  localparam int CW = $clog2(N_BITS);

  logic [N_BITS:0]   hi_q, hi_d;
  logic [N_BITS-1:0] lo_q, lo_d;
  logic [N_BITS-1:0] y_q, y_d;
  logic              div_q, div_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_BITS:0]   sum_s;
  logic [N_BITS:0]   shl_s;
  logic [N_BITS+1:0] diff_s;

  // Next-state for the accumulator/remainder, quotient/multiplier and step counter.
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    y_d    = y_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    sum_s  = hi_q + {1'b0, y_q};
    shl_s  = {hi_q[N_BITS-1:0], lo_q[N_BITS-1]};
    diff_s = {1'b0, shl_s} - {2'b00, y_q};
    if (i_load) begin
      hi_d  = '0;
      lo_d  = i_x;
      y_d   = i_y;
      div_d = i_div;
      cnt_d = '0;
    end else if (i_step) begin
      cnt_d = cnt_q + CW'(1);
      if (div_q) begin
        // Partial remainder stays below the divisor, so the top bit is a borrow only.
        if (!diff_s[N_BITS+1]) begin
          hi_d = diff_s[N_BITS:0];
          lo_d = {lo_q[N_BITS-2:0], 1'b1};
        end else begin
          hi_d = shl_s;
          lo_d = {lo_q[N_BITS-2:0], 1'b0};
        end
      end else begin
        if (lo_q[0]) begin
          hi_d = {1'b0, sum_s[N_BITS:1]};
          lo_d = {sum_s[0], lo_q[N_BITS-1:1]};
        end else begin
          hi_d = {1'b0, hi_q[N_BITS:1]};
          lo_d = {hi_q[0], lo_q[N_BITS-1:1]};
        end
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      y_q   <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      y_q   <= y_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_hi   = hi_q[N_BITS-1:0];
  assign o_lo   = lo_q;
  assign o_last = (cnt_q == CW'(N_BITS - 1));

endmodule

// File: rtl/mdu_seq.sv
// Sequential MIPS multiply/divide unit owning HI/LO: FSM, sign handling and
// result write-back around the iterative magnitude core.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int N_BITS = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [5:0]        i_op,
  input  logic [N_BITS-1:0] i_a,
  input  logic [N_BITS-1:0] i_b,
  output logic              o_busy,
  output logic              o_done,
  output logic [N_BITS-1:0] o_hi,
  output logic [N_BITS-1:0] o_lo
);

  function automatic logic [N_BITS-1:0] mag(input logic [N_BITS-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  mdu_state_e        state_q, state_d;
  logic [N_BITS-1:0] hi_q, hi_d, lo_q, lo_d, a_q, a_d;
  logic              done_q, done_d, busy_q, busy_d;
  logic              div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, div0_q, div0_d;

  logic                load_s, step_s, sa_s, sb_s;
  logic [N_BITS-1:0]   mag_a_s, mag_b_s, x_s, y_s, core_hi_s, core_lo_s, q_s, r_s;
  logic [2*N_BITS-1:0] prod_s;
  logic                core_last_s;

  mdu_iter_core #(.N_BITS(N_BITS)) u_core (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (load_s),
    .i_step  (step_s),
    .i_div   (i_op[1]),
    .i_x     (x_s),
    .i_y     (y_s),
    .o_hi    (core_hi_s),
    .o_lo    (core_lo_s),
    .o_last  (core_last_s)
  );

  // FSM next-state, operand conditioning, sign correction and HI/LO write-back.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    div0_d  = div0_q;
    done_d  = 1'b0;
    load_s  = 1'b0;
    step_s  = 1'b0;
    // Funct bit 0 clear means the signed variant (MULT/DIV).
    sa_s    = ~i_op[0] & i_a[N_BITS-1];
    sb_s    = ~i_op[0] & i_b[N_BITS-1];
    mag_a_s = mag(i_a, sa_s);
    mag_b_s = mag(i_b, sb_s);
    x_s     = i_op[1] ? mag_a_s : mag_b_s;
    y_s     = i_op[1] ? mag_b_s : mag_a_s;
    prod_s  = neg_q ? -{core_hi_s, core_lo_s} : {core_hi_s, core_lo_s};
    q_s     = neg_q ? -core_lo_s : core_lo_s;
    r_s     = rneg_q ? -core_hi_s : core_hi_s;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          case (i_op)
            FN_MTHI: hi_d = i_a;
            FN_MTLO: lo_d = i_a;
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
              load_s  = 1'b1;
              state_d = ST_RUN;
              div_d   = i_op[1];
              neg_d   = sa_s ^ sb_s;
              rneg_d  = sa_s;
              div0_d  = (i_b == '0);
              a_d     = i_a;
            end
            default: state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        step_s = 1'b1;
        if (core_last_s) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (div_q) begin
          if (div0_q) begin
            lo_d = {N_BITS{1'b1}};
            hi_d = a_q;
          end else begin
            lo_d = q_s;
            hi_d = r_s;
          end
        end else begin
          hi_d = prod_s[2*N_BITS-1:N_BITS];
          lo_d = prod_s[N_BITS-1:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Control and architectural registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      div0_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      div0_q  <= div0_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_hi   = hi_q;
  assign o_lo   = lo_q;

endmodule
